// File: rtl/btn_debounce.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// btn_debounce
//
// Front end for the four board push-buttons. Each raw button is
// polarity-corrected, synchronised into the CLK domain, and debounced by a
// stability counter. A registered press or release pulse is produced for
// every accepted change of the debounced level. The four channels are
// identical and fully independent.
//
// Parameters
//   DEBOUNCE_CYCLES : consecutive CLK cycles a changed level must hold before
//                     it is accepted (>= 2). 120000 = 10 ms at 12 MHz.
//   BTN_ACTIVE_LOW  : 1 = a low raw pin means pressed. The inversion is done
//                     ahead of the synchroniser.
//
// Ports
//   CLK         in   system clock, all state on the rising edge
//   RST_N       in   asynchronous active-low reset, used directly
//   BTN1..BTN4  in   raw buttons, asynchronous to CLK, may bounce
//   BTN_STATE   out  [3:0] debounced level, bit i-1 = BTNi, 1 = pressed
//   BTN_PRESS   out  [3:0] one-cycle pulse when a BTN_STATE bit goes 0->1
//   BTN_RELEASE out  [3:0] one-cycle pulse when a BTN_STATE bit goes 1->0
//
// Timing: if edge k is the first to sample a new raw level into the first
// synchroniser flop, BTN_STATE and the matching pulse change on edge
// k + DEBOUNCE_CYCLES + 1. Every output is a flop, so there is no
// combinational path from any BTNx pin to an output.
// -----------------------------------------------------------------------------
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 120000,
   parameter int BTN_ACTIVE_LOW  = 0
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic       BTN1,
   input  logic       BTN2,
   input  logic       BTN3,
   input  logic       BTN4,
   output logic [3:0] BTN_STATE,
   output logic [3:0] BTN_PRESS,
   output logic [3:0] BTN_RELEASE
);

   // The counter only has to reach DEBOUNCE_CYCLES-1, so clog2 bits suffice.
   localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   // Raw pins gathered into a vector and normalised so that 1 always means
   // pressed. Only a static inversion sits in front of the first flop, which
   // keeps the synchroniser input free of data-dependent logic.
   logic [3:0] pins;
   logic [3:0] raw;

   assign pins = {BTN4, BTN3, BTN2, BTN1};
   assign raw  = (BTN_ACTIVE_LOW != 0) ? ~pins : pins;

   for (genvar i = 0; i < 4; i++) begin : g_chan
      logic             s1;        // first synchroniser flop (may go metastable)
      logic             s2;        // second synchroniser flop, safe to use
      logic [CNT_W-1:0] cnt;       // cycles s2 has disagreed with state_q
      logic             state_q;   // debounced level
      logic             press_q;   // registered 0->1 pulse
      logic             rel_q;     // registered 1->0 pulse

      // NOTE: every state element uses non-blocking assignments so s1->s2 and
      // s2->state_q shift by exactly one edge each, independent of statement
      // order. The reset clears all of them asynchronously, so a count in
      // progress is discarded and a button held through reset is debounced
      // again from zero once RST_N rises.
      always_ff @(posedge CLK or negedge RST_N) begin
         if (!RST_N) begin
            s1      <= 1'b0;
            s2      <= 1'b0;
            cnt     <= '0;
            state_q <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
         end else begin
            s1      <= raw[i];
            s2      <= s1;
            // Pulses default low; they are raised only on the accepting edge
            // and therefore last exactly one cycle.
            press_q <= 1'b0;
            rel_q   <= 1'b0;

            if (s2 == state_q) begin
               // Input agrees with the accepted level: any partial count was a
               // glitch and is thrown away.
               cnt <= '0;
            end else if (cnt == CNT_MAX) begin
               // s2 has now differed on DEBOUNCE_CYCLES consecutive edges.
               // Clearing here is what keeps the counter from ever wrapping.
               cnt     <= '0;
               state_q <= s2;
               press_q <= s2;
               rel_q   <= ~s2;
            end else begin
               cnt <= cnt + CNT_ONE;
            end
         end
      end

      assign BTN_STATE[i]   = state_q;
      assign BTN_PRESS[i]   = press_q;
      assign BTN_RELEASE[i] = rel_q;
   end

endmodule

// File: tb/tb_btn_debounce.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_btn_debounce
//
// Two instances with DEBOUNCE_CYCLES = 4: one active-high (dut_hi) and one
// active-low (dut_lo), sharing clock and reset. Stimulus pushes the expected
// pulse event (cycle, press, release, state) into a per-DUT queue; a monitor
// per DUT pops and compares whenever that DUT shows any pulse. A pulse with
// nothing queued is an error, so stretched or spurious pulses are caught.
//
// Cycle numbering: cyc counts rising edges. Inputs change just after a
// falling edge when cyc == c, so edge c+1 samples them into s1 and the
// accepted change is visible after edge c+1+N+1 = c+N+2.
// -----------------------------------------------------------------------------
module tb_btn_debounce;

   localparam int N   = 4;
   localparam int LAT = N + 2;

   typedef struct {
      int unsigned cyc;
      logic [3:0]  press;
      logic [3:0]  rel;
      logic [3:0]  state;
   } evt_t;

   logic       clk;
   logic       rst_n;
   logic [3:0] btn;
   logic [3:0] al_btn;
   logic [3:0] state_hi, press_hi, rel_hi;
   logic [3:0] state_lo, press_lo, rel_lo;

   int unsigned cyc;
   int          n_checks;
   int          n_errors;
   evt_t        q_hi[$];
   evt_t        q_lo[$];
   evt_t        e_hi;
   evt_t        e_lo;

   btn_debounce #(.DEBOUNCE_CYCLES(N), .BTN_ACTIVE_LOW(0)) dut_hi (
      .CLK(clk), .RST_N(rst_n),
      .BTN1(btn[0]), .BTN2(btn[1]), .BTN3(btn[2]), .BTN4(btn[3]),
      .BTN_STATE(state_hi), .BTN_PRESS(press_hi), .BTN_RELEASE(rel_hi)
   );

   btn_debounce #(.DEBOUNCE_CYCLES(N), .BTN_ACTIVE_LOW(1)) dut_lo (
      .CLK(clk), .RST_N(rst_n),
      .BTN1(al_btn[0]), .BTN2(al_btn[1]), .BTN3(al_btn[2]), .BTN4(al_btn[3]),
      .BTN_STATE(state_lo), .BTN_PRESS(press_lo), .BTN_RELEASE(rel_lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%0h required=%0h (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   // Expected event for the stimulus applied at the current falling edge.
   task automatic push_hi(input logic [3:0] p, input logic [3:0] r, input logic [3:0] s,
                          input int unsigned delay);
      evt_t e;
      e.cyc = cyc + delay; e.press = p; e.rel = r; e.state = s;
      q_hi.push_back(e);
   endtask

   task automatic push_lo(input logic [3:0] p, input logic [3:0] r, input logic [3:0] s);
      evt_t e;
      e.cyc = cyc + LAT; e.press = p; e.rel = r; e.state = s;
      q_lo.push_back(e);
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic drain();
      int budget = 50;
      while ((q_hi.size() != 0 || q_lo.size() != 0) && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      if (q_hi.size() != 0 || q_lo.size() != 0)
         check("drain_timeout", q_hi.size() + q_lo.size(), 0);
      tick(3);
   endtask

   task automatic check_idle(input string name);
      check({name, "_state_hi"}, state_hi, 0);
      check({name, "_press_hi"}, press_hi, 0);
      check({name, "_rel_hi"},   rel_hi,   0);
      check({name, "_state_lo"}, state_lo, 0);
   endtask

   // Monitors: any pulse consumes exactly one expected event.
   always @(negedge clk) begin
      if ((press_hi | rel_hi) != 4'b0000) begin
         if (q_hi.size() == 0) begin
            check("hi_unexpected_pulse", {press_hi, rel_hi}, 0);
         end else begin
            e_hi = q_hi.pop_front();
            check("hi_cycle", cyc,      e_hi.cyc);
            check("hi_press", press_hi, e_hi.press);
            check("hi_rel",   rel_hi,   e_hi.rel);
            check("hi_state", state_hi, e_hi.state);
         end
      end
   end

   always @(negedge clk) begin
      if ((press_lo | rel_lo) != 4'b0000) begin
         if (q_lo.size() == 0) begin
            check("lo_unexpected_pulse", {press_lo, rel_lo}, 0);
         end else begin
            e_lo = q_lo.pop_front();
            check("lo_cycle", cyc,      e_lo.cyc);
            check("lo_press", press_lo, e_lo.press);
            check("lo_rel",   rel_lo,   e_lo.rel);
            check("lo_state", state_lo, e_lo.state);
         end
      end
   end

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst_n    = 1'b0;
      btn      = 4'b1111;
      al_btn   = 4'b1111;

      // Reset held with every button pressed: outputs stay 0.
      repeat (5) begin
         tick(1);
         check_idle("reset_hold");
      end

      // Release reset with BTN1 held: debounced from zero after release.
      btn = 4'b0001;
      tick(1);
      rst_n = 1'b1;
      push_hi(4'b0001, 4'b0000, 4'b0001, LAT);
      drain();
      check("state_after_reset_press", state_hi, 4'b0001);

      btn[0] = 1'b0;
      push_hi(4'b0000, 4'b0001, 4'b0000, LAT);
      drain();

      // Clean press and release on BTN1.
      btn[0] = 1'b1;
      push_hi(4'b0001, 4'b0000, 4'b0001, LAT);
      tick(14);
      check("clean_press_held", state_hi, 4'b0001);
      btn[0] = 1'b0;
      push_hi(4'b0000, 4'b0001, 4'b0000, LAT);
      drain();

      // Bounce on BTN2: 1,0,1,0 each held 2 cycles, then stable 1.
      for (int i = 0; i < 4; i++) begin
         btn[1] = (i % 2 == 0);
         tick(2);
      end
      btn[1] = 1'b1;
      push_hi(4'b0010, 4'b0000, 4'b0010, LAT);
      drain();
      btn[1] = 1'b0;
      push_hi(4'b0000, 4'b0010, 4'b0000, LAT);
      drain();

      // 3-cycle glitch: rejected, no pulse.
      btn[1] = 1'b1;
      tick(3);
      btn[1] = 1'b0;
      tick(12);
      check("glitch3_state", state_hi, 4'b0000);

      // Exactly N cycles high: accepted, then released N+2 after the fall.
      btn[1] = 1'b1;
      push_hi(4'b0010, 4'b0000, 4'b0010, LAT);
      tick(N);
      btn[1] = 1'b0;
      push_hi(4'b0000, 4'b0010, 4'b0000, LAT);
      drain();

      // Simultaneous BTN3 + BTN4.
      btn[3:2] = 2'b11;
      push_hi(4'b1100, 4'b0000, 4'b1100, LAT);
      drain();
      btn[3:2] = 2'b00;
      push_hi(4'b0000, 4'b1100, 4'b0000, LAT);
      drain();

      // Active-low instance: pins idle high, BTN1 pulled low is a press.
      check("lo_idle_state", state_lo, 4'b0000);
      al_btn[0] = 1'b0;
      push_lo(4'b0001, 4'b0000, 4'b0001);
      drain();
      check("lo_pressed_state", state_lo, 4'b0001);
      al_btn[0] = 1'b1;
      push_lo(4'b0000, 4'b0001, 4'b0000);
      drain();

      // Reset mid-operation: BTN3 accepted, BTN1 mid-count when reset hits.
      btn[2] = 1'b1;
      push_hi(4'b0100, 4'b0000, 4'b0100, LAT);
      drain();
      btn[0] = 1'b1;
      tick(2);
      rst_n = 1'b0;
      #1;
      check("midreset_state", state_hi, 4'b0000);
      check("midreset_press", press_hi, 4'b0000);
      check("midreset_rel",   rel_hi,   4'b0000);
      repeat (3) begin
         tick(1);
         check_idle("midreset_hold");
      end
      rst_n = 1'b1;
      push_hi(4'b0101, 4'b0000, 4'b0101, LAT);
      drain();
      tick(20);
      check("final_state_hi", state_hi, 4'b0101);
      check("queues_empty", q_hi.size() + q_lo.size(), 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout at cyc %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
